// File: rtl/regfile_mp.sv
// Multi-port register file with byte-enabled dual write ports and a busy scoreboard.
// Optional same-cycle read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    localparam int unsigned AW    = $clog2(NREG),
    localparam int unsigned BE_W  = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [BE_W-1:0]       wen0,
    input  logic [AW-1:0]         waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [BE_W-1:0]       wen1,
    input  logic [AW-1:0]         waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_addr,
    input  logic [AW-1:0]         test_addr,
    output logic [DATA_W-1:0]     test_data
);

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [AW-1:0]     ra;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q   <= '{default: '0};
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    // Port 1 is applied after port 0 so it wins on overlapping bytes.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int b = 0; b < BE_W; b++) begin
            if (wen0[b] && waddr0 != '0) rf_d[waddr0][b*8 +: 8] = wdata0[b*8 +: 8];
        end
        for (int b = 0; b < BE_W; b++) begin
            if (wen1[b] && waddr1 != '0) rf_d[waddr1][b*8 +: 8] = wdata1[b*8 +: 8];
        end
        if ((|wen0) && waddr0 != '0) busy_d[waddr0] = 1'b0;
        if ((|wen1) && waddr1 != '0) busy_d[waddr1] = 1'b0;
        // A new producer issued in the same cycle supersedes the retiring write.
        if (alloc_valid && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            rd_data[k*DATA_W +: DATA_W] = rf_q[ra];
            rd_busy[k] = busy_q[ra];
`ifdef RF_BYPASS_EN
            if (!reset && ra != '0) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (wen1[b] && waddr1 == ra) begin
                        rd_data[k*DATA_W + b*8 +: 8] = wdata1[b*8 +: 8];
                    end else if (wen0[b] && waddr0 == ra) begin
                        rd_data[k*DATA_W + b*8 +: 8] = wdata0[b*8 +: 8];
                    end
                end
                if ((((|wen0) && waddr0 == ra) || ((|wen1) && waddr1 == ra)) &&
                    !(alloc_valid && alloc_addr == ra)) begin
                    rd_busy[k] = 1'b0;
                end
            end
`endif
        end
    end

    assign test_data = rf_q[test_addr];

endmodule
